// File: rtl/bias_group_scheduler_if.sv
// Accumulator-in / biased-result-out stream pair for the bias scheduler.
// The scheduler takes the slave view; the adder-tree side takes master.
interface bias_group_scheduler_if #(
    parameter int N  = 16,
    parameter int DW = 18
);
    logic [N*DW-1:0] acc_in;
    logic            acc_valid;
    logic            acc_ready;
    logic [N*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output acc_in,
        output acc_valid,
        output out_ready,
        input  acc_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  acc_in,
        input  acc_valid,
        input  out_ready,
        output acc_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/bias_group_scheduler.sv
// Walks output-channel groups, selects each group's bias vector and adds
// it, saturated, to every adder-tree beat of that group.
module bias_group_scheduler #(
    parameter int N_adder_tree = 16,
    parameter int DW           = 18,
    parameter int GW           = 6,
    parameter int PW           = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [GW-1:0]              cfg_groups,
    input  logic [PW-1:0]              cfg_pixels,
    bias_group_scheduler_if.slave      s,
    output logic [GW-1:0]              bias_sel,
    input  logic [N_adder_tree*DW-1:0] bias_q,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    state_t                     state;
    state_t                     state_nx;
    logic [GW-1:0]              groups_q;
    logic [PW-1:0]              pixels_q;
    logic [PW-1:0]              pix;
    logic                       accept;
    logic                       last_pix;
    logic                       last_grp;
    logic [N_adder_tree*DW-1:0] sat;

    assign s.acc_ready = (state == RUN) & (~s.out_valid | s.out_ready);
    assign accept      = s.acc_valid & s.acc_ready;
    assign last_pix    = (pix == pixels_q - PW'(1));
    assign last_grp    = (bias_sel == groups_q - GW'(1));
    assign busy        = (state == RUN) | (state == DRAIN);
    assign done        = (state == FIN);

    // One extra bit per lane makes overflow visible as a sign disagreement.
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic [DW:0] sum;
        assign sum = {s.acc_in[DW*(i+1)-1], s.acc_in[DW*i +: DW]}
                   + {bias_q[DW*(i+1)-1], bias_q[DW*i +: DW]};
        assign sat[DW*i +: DW] = (sum[DW] == sum[DW-1]) ? sum[DW-1:0]
                               : (sum[DW] ? SMIN : SMAX);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if ((cfg_groups != '0) && (cfg_pixels != '0)) begin
                        state_nx = RUN;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            RUN: begin
                if (accept && last_pix && last_grp) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!s.out_valid || s.out_ready) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            groups_q    <= '0;
            pixels_q    <= '0;
            pix         <= '0;
            bias_sel    <= '0;
            s.out_data  <= '0;
            s.out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && start) begin
                groups_q <= cfg_groups;
                pixels_q <= cfg_pixels;
                pix      <= '0;
                bias_sel <= '0;
            end
            // bias_sel moves only after a beat, so each beat sees its own group.
            if (accept) begin
                if (last_pix) begin
                    pix      <= '0;
                    bias_sel <= last_grp ? '0 : bias_sel + GW'(1);
                end else begin
                    pix <= pix + PW'(1);
                end
            end
            if (accept) begin
                s.out_data  <= sat;
                s.out_valid <= 1'b1;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bias_group_scheduler.sv
// Randomized scoreboard bench for bias_group_scheduler: a lane-wise
// integer model predicts every result from beat order and the bias bank.
module tb_bias_group_scheduler;

    localparam int N    = 16;
    localparam int DW   = 18;
    localparam int GW   = 6;
    localparam int PW   = 12;
    localparam int SMAX = (1 << (DW - 1)) - 1;
    localparam int SMIN = -(1 << (DW - 1));

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [GW-1:0]   cfg_groups;
    logic [PW-1:0]   cfg_pixels;
    logic [GW-1:0]   bias_sel;
    logic [N*DW-1:0] bias_q;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] bank [64];

    bias_group_scheduler_if #(.N(N), .DW(DW)) bus ();

    bias_group_scheduler #(
        .N_adder_tree(N),
        .DW(DW),
        .GW(GW),
        .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_groups(cfg_groups),
        .cfg_pixels(cfg_pixels),
        .s(bus),
        .bias_sel(bias_sel),
        .bias_q(bias_q),
        .busy(busy),
        .done(done)
    );

    // External bias bank mux
    assign bias_q = bank[bias_sel];

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    logic [N*DW-1:0] expq[$];
    logic [N*DW-1:0] dq[$];
    int              beats;
    int              pops;
    int              run_total;
    int              run_pixels = 1;
    bit              got_done;
    bit              saw_busy;
    bit              prev_stall;
    bit              prev_done;
    logic [N*DW-1:0] prev_data;

    task automatic chk(input string nm, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] model(input logic [N*DW-1:0] acc,
                                              input int grp);
        logic [N*DW-1:0] r;
        int a, b, sm;
        r = '0;
        for (int i = 0; i < N; i++) begin
            a  = $signed(acc[i*DW +: DW]);
            b  = $signed(bank[grp][i*DW +: DW]);
            sm = a + b;
            if (sm > SMAX) sm = SMAX;
            else if (sm < SMIN) sm = SMIN;
            r[i*DW +: DW] = DW'(sm);
        end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        logic [DW-1:0]   l;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: l = DW'(SMAX);
                1: l = DW'(SMIN);
                2: l = DW'(int'($urandom_range(0, 2000)) - 1000);
                default: l = DW'($urandom);
            endcase
            v[i*DW +: DW] = l;
        end
        return v;
    endfunction

    // Input-side monitor: every accepted beat yields one expected result
    always @(negedge clk) begin
        if (!rst && bus.acc_valid && bus.acc_ready) begin
            chk("overrun", beats < run_total, 1);
            chk("bias_sel", bias_sel, beats / run_pixels);
            expq.push_back(model(bus.acc_in, beats / run_pixels));
            beats++;
        end
    end

    // Output-side monitor
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            chk("acc_ready_idle", bus.acc_ready && !busy, 0);
            if (busy) saw_busy = 1;
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && !bus.out_ready)
                chk("stall_acc_ready", bus.acc_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected none",
                             bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, expq.pop_front());
                end
                pops++;
            end
            if (prev_done) chk("done_width", done, 0);
            if (done) begin
                chk("busy_with_done", busy, 0);
                chk("beats_total", beats, run_total);
                chk("queue_empty", expq.size(), 0);
                chk("bias_sel_end", bias_sel, 0);
                got_done = 1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_done  = done;
        end
    end

    // mode 0 random, 1 directed dq, 2 backpressure, 3 restart attempt
    task automatic do_run(input int g, input int p, input int mode,
                          input int bp_at, output int done_c);
        bit taken;
        beats      = 0;
        pops       = 0;
        got_done   = 0;
        saw_busy   = 0;
        run_total  = g * p;
        run_pixels = (p == 0) ? 1 : p;
        done_c     = -1;
        @(posedge clk); #1;
        start      = 1;
        cfg_groups = GW'(g);
        cfg_pixels = PW'(p);
        @(posedge clk); #1;
        start      = 0;
        cfg_groups = GW'($urandom);
        cfg_pixels = PW'($urandom);
        for (int c = 0; c < 3000; c++) begin
            case (mode)
                1: begin
                    bus.out_ready = 1;
                    bus.acc_valid = (dq.size() != 0);
                    if (dq.size() != 0) bus.acc_in = dq[0];
                end
                2: begin
                    bus.acc_valid = 1;
                    bus.out_ready = !(c >= bp_at && c < bp_at + 5);
                    bus.acc_in    = rand_vec();
                end
                default: begin
                    bus.acc_valid = ($urandom_range(0, 3) != 0);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    bus.acc_in    = rand_vec();
                    if (mode == 3) begin
                        start = (c == 3);
                        if (c == 3) begin
                            cfg_groups = 1;
                            cfg_pixels = 2;
                        end
                    end
                end
            endcase
            @(negedge clk);
            taken = bus.acc_valid && bus.acc_ready;
            #1;
            if (mode == 1 && taken) void'(dq.pop_front());
            if (got_done) begin
                done_c = c;
                break;
            end
            @(posedge clk); #1;
        end
        start         = 0;
        bus.acc_valid = 0;
        bus.out_ready = 1;
        if (done_c < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done");
        end else begin
            chk("pops_total", pops, run_total);
            chk("saw_busy", saw_busy, run_total != 0);
        end
    endtask

    task automatic rst_mid_run();
        beats      = 0;
        pops       = 0;
        run_total  = 12;
        run_pixels = 4;
        @(posedge clk); #1;
        start      = 1;
        cfg_groups = 3;
        cfg_pixels = 4;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 100; c++) begin
            bus.acc_valid = 1;
            bus.out_ready = 1;
            bus.acc_in    = rand_vec();
            @(negedge clk); #1;
            if (beats == 7) break;
            @(posedge clk); #1;
        end
        chk("rst_reached_g1p2", beats, 7);
        @(posedge clk); #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        rst           = 1;
        bus.acc_valid = 0;
        @(posedge clk); #1;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_data", bus.out_data, 0);
        chk("mrst_acc_ready", bus.acc_ready, 0);
        chk("mrst_bias_sel", bias_sel, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        rst = 0;
    endtask

    initial begin
        int dc;
        logic [N*DW-1:0] v;
        rst           = 1;
        start         = 0;
        cfg_groups    = 0;
        cfg_pixels    = 0;
        bus.acc_in    = '0;
        bus.acc_valid = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 64; i++) bank[i] = rand_vec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_acc_ready", bus.acc_ready, 0);
        chk("rst_bias_sel", bias_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 0;

        // Zero accumulators: outputs are the bank vectors themselves
        for (int i = 0; i < 6; i++) dq.push_back('0);
        do_run(2, 3, 1, 0, dc);

        // Saturation corners on lane 0
        bank[0][DW-1:0] = DW'(500);
        bank[1][DW-1:0] = DW'(-12188);
        v = rand_vec(); v[DW-1:0] = 18'h1FFFF; dq.push_back(v);
        v = rand_vec(); v[DW-1:0] = 18'h1FFFF; dq.push_back(v);
        v = rand_vec(); v[DW-1:0] = 18'h20000; dq.push_back(v);
        v = rand_vec(); v[DW-1:0] = DW'(1000);  dq.push_back(v);
        do_run(2, 2, 1, 0, dc);

        do_run(2, 4, 2, 2, dc);
        do_run(3, 0, 0, 0, dc);
        chk("empty_done_latency", dc <= 1, 1);
        do_run(0, 5, 0, 0, dc);
        do_run(3, 4, 3, 0, dc);
        rst_mid_run();
        do_run(2, 3, 0, 0, dc);
        for (int r = 0; r < 6; r++)
            do_run($urandom_range(1, 4), $urandom_range(1, 5), 0, 0, dc);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
